// File: rtl/prog_chain_pkg.sv
// Shared types and sizing helpers for the configuration scan-chain driver.
// Pulled in by the driver FSM, its phase divider and the bench.
package prog_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_FETCH,
        LD_SHIFT,
        RB_SHIFT,
        RB_PUSH,
        TAIL
    } state_t;

    localparam int DEF_CHAIN_LEN = 20;
    localparam int DEF_WORD_W    = 8;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_NUM_WORDS = (DEF_CHAIN_LEN + DEF_WORD_W - 1) / DEF_WORD_W;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/prog_chain_driver_clk_gen.sv
// Phase divider for prog_clk: CLK_DIV low cycles then CLK_DIV high cycles while run is high.
// When stalled it always rests at the start of a low phase, so no partial pulses appear.
module prog_clk_gen
    import prog_chain_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic prog_clk,
    output logic low_first,
    output logic rise,
    output logic period_end
);

    localparam int PH_W = cnt_width(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    logic [PH_W-1:0] phase_reg;
    logic            high_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
            high_reg  <= 1'b0;
        end else if (run) begin
            if (phase_reg == PH_LAST) begin
                phase_reg <= '0;
                high_reg  <= ~high_reg;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
        end
    end

    assign prog_clk   = high_reg;
    assign low_first  = run && !high_reg && (phase_reg == '0);
    assign rise       = run && !high_reg && (phase_reg == PH_LAST);
    assign period_end = run &&  high_reg && (phase_reg == PH_LAST);

endmodule

// File: rtl/prog_chain_driver.sv
// Master-side driver for the FPGA configuration chain: serialises load words LSB-first,
// or recirculates the chain once to read it back as words without disturbing it.
module prog_chain_driver
    import prog_chain_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_read,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              prog_clk,
    output logic              prog_en,
    output logic              prog_in,
    input  logic              prog_out
);

    localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int BC_W = cnt_width(CHAIN_LEN + 1);
    localparam int WB_W = cnt_width(WORD_W + 1);
    localparam int WI_W = cnt_width(NUM_WORDS);
    localparam int TL_W = cnt_width(CLK_DIV);
    localparam logic [BC_W-1:0] BC_END  = BC_W'(CHAIN_LEN);
    localparam logic [WB_W-1:0] WB_END  = WB_W'(WORD_W);
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(NUM_WORDS - 1);
    localparam logic [TL_W-1:0] TL_LAST = TL_W'(CLK_DIV - 1);

    state_t            state_reg;
    logic [BC_W-1:0]   bit_cnt_reg;
    logic [WB_W-1:0]   word_bits_reg;
    logic [WI_W-1:0]   word_idx_reg;
    logic [TL_W-1:0]   tail_cnt_reg;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] cap_reg;
    logic              busy_reg, done_reg, wr_ready_reg, rd_valid_reg, en_reg, in_reg;
    logic [WORD_W-1:0] rd_data_reg;
    logic              run, low_first, rise, period_end;

    assign run = (state_reg == LD_SHIFT) || (state_reg == RB_SHIFT);

    prog_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .prog_clk   (prog_clk),
        .low_first  (low_first),
        .rise       (rise),
        .period_end (period_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            word_bits_reg <= '0;
            word_idx_reg  <= '0;
            tail_cnt_reg  <= '0;
            shift_reg     <= '0;
            cap_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            wr_ready_reg  <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            en_reg        <= 1'b0;
            in_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_load) begin
                        state_reg    <= LD_FETCH;
                        busy_reg     <= 1'b1;
                        en_reg       <= 1'b1;
                        wr_ready_reg <= 1'b1;
                        bit_cnt_reg  <= '0;
                    end else if (start_read) begin
                        state_reg     <= RB_SHIFT;
                        busy_reg      <= 1'b1;
                        en_reg        <= 1'b1;
                        bit_cnt_reg   <= '0;
                        word_bits_reg <= '0;
                        word_idx_reg  <= '0;
                        cap_reg       <= '0;
                    end
                end
                LD_FETCH: begin
                    if (wr_valid && wr_ready_reg) begin
                        shift_reg     <= wr_data;
                        word_bits_reg <= '0;
                        wr_ready_reg  <= 1'b0;
                        state_reg     <= LD_SHIFT;
                    end
                end
                LD_SHIFT: begin
                    if (low_first) begin
                        in_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                    if (rise) begin
                        bit_cnt_reg   <= bit_cnt_reg + 1'b1;
                        word_bits_reg <= word_bits_reg + 1'b1;
                    end
                    // Counts already include the bit whose period is ending.
                    if (period_end) begin
                        if (bit_cnt_reg == BC_END) begin
                            state_reg    <= TAIL;
                            tail_cnt_reg <= '0;
                        end else if (word_bits_reg == WB_END) begin
                            state_reg    <= LD_FETCH;
                            wr_ready_reg <= 1'b1;
                        end
                    end
                end
                RB_SHIFT: begin
                    // Recirculate: the bit leaving the chain end is fed straight back in.
                    if (low_first) begin
                        in_reg  <= prog_out;
                        cap_reg <= cap_reg | (WORD_W'(prog_out) << word_bits_reg);
                    end
                    if (rise) begin
                        bit_cnt_reg   <= bit_cnt_reg + 1'b1;
                        word_bits_reg <= word_bits_reg + 1'b1;
                    end
                    if (period_end && (word_bits_reg == WB_END || bit_cnt_reg == BC_END)) begin
                        state_reg    <= RB_PUSH;
                        rd_valid_reg <= 1'b1;
                        rd_data_reg  <= cap_reg;
                    end
                end
                RB_PUSH: begin
                    if (rd_ready) begin
                        rd_valid_reg <= 1'b0;
                        if (word_idx_reg == WI_LAST) begin
                            state_reg    <= TAIL;
                            tail_cnt_reg <= '0;
                        end else begin
                            state_reg     <= RB_SHIFT;
                            word_idx_reg  <= word_idx_reg + 1'b1;
                            word_bits_reg <= '0;
                            cap_reg       <= '0;
                        end
                    end
                end
                TAIL: begin
                    if (tail_cnt_reg == TL_LAST) begin
                        en_reg    <= 1'b0;
                        in_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        tail_cnt_reg <= tail_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign wr_ready = wr_ready_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign prog_en  = en_reg;
    assign prog_in  = in_reg;

endmodule
